// File: rtl/addsub_seq_if.sv
// Operand/result handshake bundle for addsub_seq.
// The master drives operands and out_ready; the slave (the adder) returns the result and flags.
interface addsub_seq_if #(
  parameter int N = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] s;
  logic         cout;
  logic         ovf;
  logic         zero;

  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf, zero
  );
endinterface

// File: rtl/addsub_seq.sv
// Multi-cycle add/subtract: CHUNK bits per CALC beat, N/CHUNK beats per operation.
// Define ADDSUB_SAT_EN to clamp signed-overflowing results to the signed extreme.
module addsub_seq #(
  parameter int N     = 8,
  parameter int CHUNK = 4
) (
  input logic         clk,
  input logic         rst_n,
  addsub_seq_if.slave bus
);
  // N must be a multiple of CHUNK and bus must be instantiated with the same N.
  localparam int NB = N / CHUNK;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [N-1:0]    a_q, a_d;
  logic [N-1:0]    b_q, b_d;
  logic [N-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic [CHUNK-1:0] a_sl [NB];
  logic [CHUNK-1:0] b_sl [NB];

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_slice
      assign a_sl[gi] = a_q[gi*CHUNK +: CHUNK];
      assign b_sl[gi] = b_q[gi*CHUNK +: CHUNK];
    end
  endgenerate

  logic [CHUNK:0] slice_sum;
  logic [N-1:0]   raw_s;
  logic [N-1:0]   final_s;
  logic           raw_ovf;
  logic           last_beat;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    slice_sum = '0;
    raw_s     = s_q;
    final_s   = s_q;
    raw_ovf   = 1'b0;
    last_beat = (cnt_q == CW'(NB - 1));

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b ^ {N{bus.sub}};
          carry_d = bus.sub;
          cnt_d   = '0;
          state_d = CALC;
        end
      end

      CALC: begin
        slice_sum = {1'b0, a_sl[cnt_q]} + {1'b0, b_sl[cnt_q]} + {{CHUNK{1'b0}}, carry_q};
        for (int i = 0; i < NB; i++) begin
          if (cnt_q == CW'(i)) raw_s[i*CHUNK +: CHUNK] = slice_sum[CHUNK-1:0];
        end
        s_d     = raw_s;
        carry_d = slice_sum[CHUNK];
        cnt_d   = cnt_q + CW'(1);

        if (last_beat) begin
          // b_q already holds the conditionally inverted operand, so one rule covers add and sub.
          raw_ovf = (a_q[N-1] == b_q[N-1]) && (raw_s[N-1] != a_q[N-1]);
`ifdef ADDSUB_SAT_EN
          if (raw_ovf) final_s = a_q[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
          else         final_s = raw_s;
`else
          final_s = raw_s;
`endif
          s_d     = final_s;
          cout_d  = slice_sum[CHUNK];
          ovf_d   = raw_ovf;
          zero_d  = (final_s == '0);
          cnt_d   = '0;
          state_d = DONE;
        end
      end

      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq (N=4, CHUNK=2): directed vectors plus a signed/unsigned arithmetic model.
module tb_addsub_seq;
  localparam int N     = 4;
  localparam int CHUNK = 2;
  localparam int NB    = N / CHUNK;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  addsub_seq_if #(.N(N)) bus ();

  addsub_seq #(.N(N), .CHUNK(CHUNK)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [N-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;
  } res_t;

  int   chk_cnt  = 0;
  int   pass_cnt = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  bit   prev_ov  = 1'b0;
  res_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    chk_cnt++;
    if (act === req) pass_cnt++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Arithmetic reference: true signed/unsigned results, independent of beat structure.
  function automatic res_t model(input logic [N-1:0] ma, input logic [N-1:0] mb, input logic ms);
    res_t r;
    int ua, ub, sa, sb, t, u;
    logic [31:0] uv;
    ua = int'(ma);
    ub = int'(mb);
    sa = ua - (ma[N-1] ? (1 << N) : 0);
    sb = ub - (mb[N-1] ? (1 << N) : 0);
    t  = ms ? sa - sb : sa + sb;
    u  = ms ? ua - ub : ua + ub;
    uv = u;
    r.ovf  = (t > (1 << (N-1)) - 1) || (t < -(1 << (N-1)));
    r.cout = ms ? (ua >= ub) : (u >= (1 << N));
    r.s    = uv[N-1:0];
`ifdef ADDSUB_SAT_EN
    if (r.ovf) r.s = ma[N-1] ? (N)'(1 << (N-1)) : (N)'((1 << (N-1)) - 1);
`endif
    r.zero = (r.s == '0);
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Compare process: every cycle out_valid is high, outputs must match the model's head entry.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.sub));
        acc_cyc = cyc + 1;
      end
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("model_s",    32'(bus.s),    32'(exp_q[0].s));
          chk("model_cout", 32'(bus.cout), 32'(exp_q[0].cout));
          chk("model_ovf",  32'(bus.ovf),  32'(exp_q[0].ovf));
          chk("model_zero", 32'(bus.zero), 32'(exp_q[0].zero));
          if (!prev_ov) chk("model_latency", 32'(cyc - acc_cyc), 32'(NB));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end
      prev_ov = bus.out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic ts,
                       input logic [N-1:0] es, input logic ec, input logic eo, input logic ez,
                       input int hold, input bit lit);
    int n;
    logic [N-1:0] s_hold;
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.a = ta; bus.b = tb; bus.sub = ts; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.a = ~ta; bus.b = ~tb; bus.sub = ~ts;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk("latency", 32'(n), 32'(NB));
    if (lit) begin
      chk("lit_s",    32'(bus.s),    32'(es));
      chk("lit_cout", 32'(bus.cout), 32'(ec));
      chk("lit_ovf",  32'(bus.ovf),  32'(eo));
      chk("lit_zero", 32'(bus.zero), 32'(ez));
    end
    s_hold = bus.s;
    for (int h = 0; h < hold; h++) begin
      bus.in_valid = 1'b1;
      bus.a = 4'(h + 3);
      tick();
      chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_in_ready",  32'(bus.in_ready),  32'd0);
      chk("hold_s",         32'(bus.s),         32'(s_hold));
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("release_out_valid", 32'(bus.out_valid), 32'd0);
    chk("release_in_ready",  32'(bus.in_ready),  32'd1);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.sub = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_s",         32'(bus.s),         32'd0);
    chk("rst_flags",     32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
    rst_n = 1'b1;
    tick();

    // Pin the model itself against hand-computed results.
    begin
      res_t m;
      m = model(4'b0111, 4'b0001, 1'b0);
      chk("pin_model_ovf", 32'(m.ovf), 32'd1);
      m = model(4'b0000, 4'b0001, 1'b1);
      chk("pin_model_sub", 32'({m.s, m.cout}), 32'({4'b1111, 1'b0}));
    end

    do_op(4'b0000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    do_op(4'b0000, 4'b0001, 1'b1, 4'b1111, 1'b0, 1'b0, 1'b0, 0, 1'b1);
    do_op(4'b0010, 4'b0010, 1'b1, 4'b0000, 1'b1, 1'b0, 1'b1, 0, 1'b1);
`ifdef ADDSUB_SAT_EN
    do_op(4'b0111, 4'b0001, 1'b0, 4'b0111, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    do_op(4'b1000, 4'b0001, 1'b1, 4'b1000, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    do_op(4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1, 1'b0, 0, 1'b1);
`else
    do_op(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 0, 1'b1);
    do_op(4'b1000, 4'b0001, 1'b1, 4'b0111, 1'b1, 1'b1, 1'b0, 3, 1'b1);
    do_op(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 0, 1'b1);
`endif
    do_op(4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1, 1'b1);

    for (int i = 0; i < 24; i++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
            4'd0, 1'b0, 1'b0, 1'b0, 0, 1'b0);
    end

    // Reset in the first CALC cycle aborts the operation.
    bus.a = 4'b0011; bus.b = 4'b0101; bus.sub = 1'b0; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    chk("abort_in_ready",  32'(bus.in_ready),  32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_s",         32'(bus.s),         32'd0);
    chk("abort_flags",     32'({bus.cout, bus.ovf, bus.zero}), 32'd0);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("abort_no_result", 32'(bus.out_valid), 32'd0);
    end

    do_op(4'b0101, 4'b0011, 1'b1, 4'b0010, 1'b1, 1'b0, 1'b0, 0, 1'b1);
    tick();
    chk("model_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
